rgb_pwm_decoder: RTL and testbench

Receive-side counterpart of the RGB gaming-LED PWM driver. It samples three active-low 8-bit PWM LED lines and measures the low-time of each over a fixed 256-cycle window. It recovers the 8-bit intensity of each channel and presents the triple on a valid/ready interface. Used for loopback self-test of LED drivers and for mirroring LED state to a host-side status register.

---
 rtl/rgb_pwm_pkg.sv | 30 +++
 rtl/rgb_pwm_decoder_duty_counter.sv | 73 +++++++
 rtl/rgb_pwm_decoder.sv | 95 +++++++++
 tb/tb_rgb_pwm_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared types and helpers for the RGB PWM decoder.
// Optional glitch filter: define RGB_PWM_DECODER_GLITCH_FILTER_EN.
package rgb_pwm_pkg;

    localparam int unsigned PWM_PERIOD_DEFAULT = 256;
    localparam int unsigned CH_R = 2;
    localparam int unsigned CH_G = 1;
    localparam int unsigned CH_B = 0;

    // Widest low-count any legal PWM_PERIOD (up to 1024) can produce.
    localparam int unsigned CNT_W_MAX = 11;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    // The driver holds the line low for X+1 cycles at intensity X.
    function automatic logic [7:0] sat_intensity(input logic [CNT_W_MAX-1:0] count);
        if (count == '0) begin
            return '0;
        end
        if (count > CNT_W_MAX'(256)) begin
            return '1;
        end
        return 8'(count - CNT_W_MAX'(1));
    endfunction

endpackage

// File: rtl/rgb_pwm_decoder_duty_counter.sv
// Per-channel synchronizer, optional majority filter, low-time accumulator.
// Glitch filter enabled by RGB_PWM_DECODER_GLITCH_FILTER_EN.
module pwm_duty_counter
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PWM_PERIOD  = PWM_PERIOD_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       led_n_i,
    input  logic       win_end_i,
    output logic [7:0] intensity_o
);

    localparam int unsigned CW = $clog2(PWM_PERIOD) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample_n;
    logic [CW-1:0]          acc_q;
    logic [CW-1:0]          acc_d;
    logic [CW-1:0]          count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], led_n_i};
        end
    end

`ifdef RGB_PWM_DECODER_GLITCH_FILTER_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '1;
        end else begin
            hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
        end
    end

    // Majority of the current and two previous samples; both edges shift by one cycle.
    always_comb begin
        sample_n = (sync_q[SYNC_STAGES-1] & hist_q[0]) |
                   (sync_q[SYNC_STAGES-1] & hist_q[1]) |
                   (hist_q[0] & hist_q[1]);
    end
`else
    always_comb begin
        sample_n = sync_q[SYNC_STAGES-1];
    end
`endif

    // count already includes this cycle's sample, so clearing at window end loses nothing.
    always_comb begin
        count = acc_q + CW'(!sample_n);
        acc_d = win_end_i ? '0 : count;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        intensity_o = sat_intensity(CNT_W_MAX'(count));
    end

endmodule

// File: rtl/rgb_pwm_decoder.sv
// Top level: window counter, result registers and valid/ready/overrun logic.
// Glitch filter enabled by RGB_PWM_DECODER_GLITCH_FILTER_EN.
module rgb_pwm_decoder
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PWM_PERIOD  = PWM_PERIOD_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       iCLOCK,
    input  logic       iRESET,
    input  logic [2:0] iLED,
    output logic [7:0] oR,
    output logic [7:0] oG,
    output logic [7:0] oB,
    output logic       oVALID,
    input  logic       iREADY,
    output logic       oOVERRUN
);

    localparam int unsigned WW = $clog2(PWM_PERIOD);

    logic [WW-1:0] win_q;
    logic [WW-1:0] win_d;
    logic          win_end;
    logic [7:0]    int_r;
    logic [7:0]    int_g;
    logic [7:0]    int_b;
    rgb8_t         fresh;
    rgb8_t         data_q;
    rgb8_t         data_d;
    logic          valid_q;
    logic          valid_d;
    logic          ovr_q;
    logic          ovr_d;
    logic          handshake;

    pwm_duty_counter #(.PWM_PERIOD(PWM_PERIOD), .SYNC_STAGES(SYNC_STAGES)) u_red (
        .clk_i(iCLOCK), .rst_i(iRESET), .led_n_i(iLED[CH_R]),
        .win_end_i(win_end), .intensity_o(int_r)
    );

    pwm_duty_counter #(.PWM_PERIOD(PWM_PERIOD), .SYNC_STAGES(SYNC_STAGES)) u_green (
        .clk_i(iCLOCK), .rst_i(iRESET), .led_n_i(iLED[CH_G]),
        .win_end_i(win_end), .intensity_o(int_g)
    );

    pwm_duty_counter #(.PWM_PERIOD(PWM_PERIOD), .SYNC_STAGES(SYNC_STAGES)) u_blue (
        .clk_i(iCLOCK), .rst_i(iRESET), .led_n_i(iLED[CH_B]),
        .win_end_i(win_end), .intensity_o(int_b)
    );

    always_comb begin
        win_end   = (win_q == WW'(PWM_PERIOD - 1));
        win_d     = win_end ? '0 : win_q + WW'(1);
        fresh     = '{r: int_r, g: int_g, b: int_b};
        handshake = valid_q && iREADY;
        data_d    = data_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        // A window end always wins: new data lands even if the consumer is mid-handshake.
        if (win_end) begin
            data_d  = fresh;
            valid_d = 1'b1;
            if (valid_q && !iREADY) begin
                ovr_d = 1'b1;
            end else if (handshake) begin
                ovr_d = 1'b0;
            end
        end else if (handshake) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            win_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            win_q   <= win_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign oR       = data_q.r;
    assign oG       = data_q.g;
    assign oB       = data_q.b;
    assign oVALID   = valid_q;
    assign oOVERRUN = ovr_q;

endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// Self-checking bench for rgb_pwm_decoder against a sample-history reference model.
module tb_rgb_pwm_decoder;

    localparam int PER = 256;

    logic       iCLOCK = 1'b0;
    logic       iRESET = 1'b1;
    logic [2:0] iLED   = 3'b111;
    logic       iREADY = 1'b0;
    logic [7:0] oR;
    logic [7:0] oG;
    logic [7:0] oB;
    logic       oVALID;
    logic       oOVERRUN;

    rgb_pwm_decoder #(.PWM_PERIOD(PER), .SYNC_STAGES(2)) dut (
        .iCLOCK(iCLOCK), .iRESET(iRESET), .iLED(iLED),
        .oR(oR), .oG(oG), .oB(oB),
        .oVALID(oVALID), .iREADY(iREADY), .oOVERRUN(oOVERRUN)
    );

    always #5 iCLOCK = ~iCLOCK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: every LED value seen since reset release, per-channel low counts.
    logic [2:0] hist[$];
    int         cyc = 0;
    int         acc[3];
    int         m_int[3];
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;

    // Stimulus generator state.
    int         t_abs = 0;
    int         mode  = 0;
    logic [2:0] led_const = 3'b111;
    int         ival[3];
    int         ph[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat8(input int c);
        if (c == 0) return 0;
        if (c - 1 > 255) return 255;
        return c - 1;
    endfunction

    // LED value that reaches the counter at edge j: two synchronizer stages, reset value 1.
    function automatic logic [2:0] s_at(input int j);
        if (j < 2) return 3'b111;
        return hist[j-2];
    endfunction

    task automatic model_step(input logic [2:0] led_now, input logic rdy_now, input logic rst_now);
        logic [2:0] a, b, c, f;
        if (rst_now) begin
            cyc = 0;
            hist.delete();
            for (int i = 0; i < 3; i++) begin
                acc[i]   = 0;
                m_int[i] = 0;
            end
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            return;
        end
        hist.push_back(led_now);
        a = s_at(cyc);
        b = s_at(cyc - 1);
        c = s_at(cyc - 2);
`ifdef RGB_PWM_DECODER_GLITCH_FILTER_EN
        f = (a & b) | (a & c) | (b & c);
`else
        f = a;
`endif
        for (int i = 0; i < 3; i++) begin
            if (!f[i]) acc[i]++;
        end
        if (cyc % PER == PER - 1) begin
            for (int i = 0; i < 3; i++) begin
                m_int[i] = sat8(acc[i]);
                acc[i]   = 0;
            end
            if (m_valid && !rdy_now) m_ovr = 1'b1;
            else if (m_valid && rdy_now) m_ovr = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid && rdy_now) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        cyc++;
    endtask

    task automatic drive();
        int pos;
        case (mode)
            0: iLED = led_const;
            1: begin
                for (int i = 0; i < 3; i++) begin
                    iLED[i] = !(((t_abs + ph[i]) % PER) < ival[i] + 1);
                end
            end
            2: begin
                iLED   = 3'($urandom);
                iREADY = 1'($urandom);
            end
            default: begin
                // Red at 100 with a one-cycle high spike in the middle of its low run.
                pos  = (t_abs + ph[2]) % PER;
                iLED = {!(pos < 101 && pos != 50), 2'b11};
            end
        endcase
    endtask

    task automatic tick();
        logic [2:0] led_now;
        logic       rdy_now, rst_now;
        drive();
        led_now = iLED;
        rdy_now = iREADY;
        rst_now = iRESET;
        @(posedge iCLOCK);
        model_step(led_now, rdy_now, rst_now);
        t_abs++;
        #1;
        chk("valid", oVALID, m_valid);
        chk("overrun", oOVERRUN, m_ovr);
        chk("r", oR, m_int[2]);
        chk("g", oG, m_int[1]);
        chk("b", oB, m_int[0]);
    endtask

    task automatic new_phases();
        for (int i = 0; i < 3; i++) ph[i] = $urandom_range(0, PER - 1);
    endtask

    initial begin
        int n;

        // Reset and idle line.
        mode = 0; led_const = 3'b111; iREADY = 1'b1; iRESET = 1'b1;
        repeat (3) tick();
        chk("rst_valid", oVALID, 0);
        chk("rst_r", oR, 0);
        iRESET = 1'b0;
        n = 0;
        while (oVALID !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("first_valid_cycle", n, PER);
        chk("idle_r", oR, 0);
        repeat (PER) tick();

        // Driver-model PWM with random phases.
        mode = 1; ival[2] = 128; ival[1] = 16; ival[0] = 255; new_phases();
        repeat (3 * PER) tick();
        chk("pwm_r128", oR, 128);
        chk("pwm_g16", oG, 16);
        chk("pwm_b255", oB, 255);

        // All lines held low saturate at 255.
        mode = 0; led_const = 3'b000;
        repeat (2 * PER + 10) tick();
        chk("low_r", oR, 255);
        chk("low_g", oG, 255);
        chk("low_b", oB, 255);

        // One low cycle decodes to zero.
        mode = 1; ival[2] = 0; ival[1] = 200; ival[0] = 1; new_phases();
        repeat (2 * PER + 10) tick();
        chk("min_r0", oR, 0);
        chk("min_g200", oG, 200);
        chk("min_b1", oB, 1);

        // Consumer stalls across several windows.
        iREADY = 1'b0;
        ival[2] = 10; repeat (PER) tick();
        ival[2] = 20; repeat (PER) tick();
        ival[2] = 30; repeat (2 * PER + 10) tick();
        chk("ovr_r30", oR, 30);
        chk("ovr_valid", oVALID, 1);
        chk("ovr_flag", oOVERRUN, 1);
        while (cyc % PER != 10) tick();
        iREADY = 1'b1;
        tick();
        iREADY = 1'b0;
        chk("hs_valid", oVALID, 0);
        chk("hs_ovr", oOVERRUN, 0);
        iREADY = 1'b1;

        // Reset in the middle of a window.
        ival[2] = 77; ival[1] = 5; ival[0] = 140; new_phases();
        while (cyc % PER != 100) tick();
        iRESET = 1'b1;
        tick();
        iRESET = 1'b0;
        chk("mid_rst_valid", oVALID, 0);
        chk("mid_rst_ovr", oOVERRUN, 0);
        chk("mid_rst_r", oR, 0);
        chk("mid_rst_g", oG, 0);
        chk("mid_rst_b", oB, 0);
        n = 0;
        while (oVALID !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("valid_after_rst", n, PER);
        repeat (PER) tick();
        chk("after_rst_r77", oR, 77);

        // Random lines and random ready.
        mode = 2;
        repeat (4 * PER) tick();

        // One-cycle glitch inside the red low run.
        mode = 3; iREADY = 1'b1; new_phases();
        repeat (3 * PER) tick();
`ifdef RGB_PWM_DECODER_GLITCH_FILTER_EN
        chk("glitch_r", oR, 100);
`else
        chk("glitch_r", oR, 99);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
